// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one fixed-latency single-port memory between instruction
//            fetch and the MEM stage. Each access runs grant -> wait -> ack.
//            Optional starvation guard: define MEM_ARB_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ack,
  output logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_en,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_gnt_mem;
  logic        r_we;
  logic [3:0]  r_wait;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_mem_rdata;
  logic        w_grant;
  logic        w_grant_mem;
  logic        w_force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
  // Counts consecutive MEM wins that left a fetch waiting.
  logic [3:0] r_starve;

  assign w_force_if = (r_starve == 4'(STARVE_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_grant) begin
      if (!w_grant_mem) begin
        r_starve <= '0;
      end else if (if_req && (r_starve != 4'(STARVE_MAX))) begin
        r_starve <= r_starve + 4'd1;
      end
    end
  end
`else
  // Strict priority: MEM always wins; STARVE_MAX has no effect here.
  assign w_force_if = 1'b0 & (STARVE_MAX == 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_mem = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (if_req || mem_req) begin
          w_grant     = 1'b1;
          w_grant_mem = mem_req & ~(if_req & w_force_if);
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_wait == 4'd0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt_mem   <= 1'b0;
      r_we        <= 1'b0;
      r_wait      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else if (w_grant) begin
      r_gnt_mem <= w_grant_mem;
      r_wait    <= 4'(LAT - 1);
      if (w_grant_mem) begin
        r_addr  <= mem_addr;
        r_we    <= mem_we;
        r_wdata <= mem_wdata;
      end else begin
        r_addr  <= if_addr;
      end
    end else if (r_state == S_BUSY) begin
      if (r_wait == 4'd0) begin
        // Memory data is valid only in the final BUSY cycle.
        if (r_gnt_mem) begin
          r_mem_rdata <= r_we ? 32'd0 : bus_rdata;
        end else begin
          r_if_rdata  <= bus_rdata;
        end
      end else begin
        r_wait <= r_wait - 4'd1;
      end
    end
  end

  assign bus_en    = (r_state == S_BUSY);
  assign bus_we    = bus_en & r_gnt_mem & r_we;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;

  assign if_ack    = (r_state == S_DONE) & ~r_gnt_mem;
  assign mem_ack   = (r_state == S_DONE) &  r_gnt_mem;
  assign if_rdata  = r_if_rdata;
  assign mem_rdata = r_mem_rdata;

  assign stall_if  = if_req  & ~if_ack;
  assign stall_mem = mem_req & ~mem_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-timeline model.
module tb_mem_port_arbiter;

  localparam int LAT        = 2;
  localparam int STARVE_MAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_en;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(.LAT(LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .bus_en(bus_en), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: m_age counts cycles since the grant (-1 = arbitration cycle).
  int          m_age = -1;
  int          m_starve = 0;
  bit          m_own_mem = 1'b0;
  bit          m_we = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_if_rdata = '0;
  logic [31:0] m_mem_rdata = '0;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      m_age = -1; m_starve = 0; m_own_mem = 1'b0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_mem_rdata = '0;
    end else begin
      bit e_en, e_done;
      e_en   = (m_age >= 1) && (m_age <= LAT);
      e_done = (m_age == LAT + 1);
      chk("m_bus_en", 32'(bus_en), 32'(e_en));
      chk("m_bus_we", 32'(bus_we), 32'(e_en && m_own_mem && m_we));
      chk("m_bus_addr", bus_addr, m_addr);
      chk("m_bus_wdata", bus_wdata, m_wdata);
      chk("m_if_ack", 32'(if_ack), 32'(e_done && !m_own_mem));
      chk("m_mem_ack", 32'(mem_ack), 32'(e_done && m_own_mem));
      if (e_done && !m_own_mem) chk("m_if_rdata", if_rdata, m_if_rdata);
      if (e_done && m_own_mem)  chk("m_mem_rdata", mem_rdata, m_mem_rdata);
      chk("m_stall_if", 32'(stall_if), 32'(if_req && !(e_done && !m_own_mem)));
      chk("m_stall_mem", 32'(stall_mem), 32'(mem_req && !(e_done && m_own_mem)));
      if (m_age == -1) begin
        if (if_req || mem_req) begin
          m_own_mem = mem_req && !(if_req && GUARD && m_starve == STARVE_MAX);
          if (m_own_mem) begin
            if (if_req && m_starve < STARVE_MAX) m_starve++;
            m_addr = mem_addr; m_we = mem_we; m_wdata = mem_wdata;
          end else begin
            m_starve = 0;
            m_addr = if_addr;
          end
          m_age = 1;
        end
      end else if (m_age == LAT + 1) begin
        m_age = -1;
      end else begin
        if (m_age == LAT) begin
          if (m_own_mem) m_mem_rdata = m_we ? 32'd0 : bus_rdata;
          else           m_if_rdata  = bus_rdata;
        end
        m_age++;
      end
    end
  end

  initial begin
    int n_ack;
    int first_if;
    bit if_seen, mem_seen;

    #2;
    chk("rst_bus_en", 32'(bus_en), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_acks", 32'({if_ack, mem_ack}), 32'd0);
    chk("rst_rdata", if_rdata | mem_rdata, 32'd0);
    @(posedge clk); #2 rst = 1'b0;

    // Single fetch
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0000_0010; bus_rdata = 32'h0010_0093;
    for (int c = 0; c < 5; c++) begin
      #4;
      chk("if_bus_en", 32'(bus_en), 32'(c == 1 || c == 2));
      if (c == 1) chk("if_bus_addr", bus_addr, 32'h10);
      chk("if_ack_cycle", 32'(if_ack), 32'(c == 3));
      if (c == 3) chk("if_rdata", if_rdata, 32'h0010_0093);
      chk("if_stall", 32'(stall_if), 32'(c <= 2));
      @(posedge clk); #1;
      if (c == 3) if_req = 1'b0;
    end

    // Store
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h4000; mem_wdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 5; c++) begin
      #4;
      chk("st_bus_we", 32'(bus_we), 32'(c == 1 || c == 2));
      if (c == 1) chk("st_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
      chk("st_mem_ack", 32'(mem_ack), 32'(c == 3));
      if (c == 3) chk("st_mem_rdata", mem_rdata, 32'd0);
      chk("st_no_if_ack", 32'(if_ack), 32'd0);
      @(posedge clk); #1;
      if (c == 3) mem_req = 1'b0;
    end

    // Simultaneous requests: MEM first, then IF
    mem_we = 1'b0; mem_addr = 32'h100; if_addr = 32'h20;
    mem_req = 1'b1; if_req = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #4;
      chk("both_mem_ack", 32'(mem_ack), 32'(c == 3));
      chk("both_if_ack", 32'(if_ack), 32'(c == 7));
      @(posedge clk); #1;
      if (c == 3) mem_req = 1'b0;
      if (c == 7) if_req = 1'b0;
    end

    // Both held high: count grants until the first IF win
    mem_req = 1'b1; if_req = 1'b1; mem_addr = 32'h200; if_addr = 32'h300;
    n_ack = 0; first_if = 0;
    for (int c = 0; c < 200 && n_ack < 5; c++) begin
      @(negedge clk);
      if (mem_ack || if_ack) begin
        n_ack++;
        if (if_ack && first_if == 0) first_if = n_ack;
      end
      @(posedge clk); #1;
    end
    mem_req = 1'b0; if_req = 1'b0;
    chk("starve_ack_count", n_ack, 5);
    chk("starve_first_if_grant", first_if, GUARD ? STARVE_MAX + 1 : 0);

    // Reset during BUSY of a load
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h80;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("rst_mid_pre_en", 32'(bus_en), 32'd1);
    rst = 1'b1; #1;
    chk("rst_mid_en_drop", 32'(bus_en), 32'd0);
    chk("rst_mid_addr", bus_addr, 32'd0);
    mem_req = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rst_mid_no_ack", 32'({if_ack, mem_ack}), 32'd0);
    end
    @(posedge clk); #1;
    mem_req = 1'b1; mem_addr = 32'h84; bus_rdata = 32'h1234_5678;
    for (int c = 0; c < 5; c++) begin
      #4;
      chk("post_rst_ack", 32'(mem_ack), 32'(c == 3));
      if (c == 3) chk("post_rst_rdata", mem_rdata, 32'h1234_5678);
      @(posedge clk); #1;
      if (c == 3) mem_req = 1'b0;
    end

    // Randomized traffic with occasional asynchronous resets
    if_seen = 1'b0; mem_seen = 1'b0;
    repeat (3000) begin
      @(posedge clk); #1;
      bus_rdata = $urandom;
      if (if_req && if_seen) begin
        if ($urandom_range(0, 7) != 0) if_req = 1'b0;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (mem_req && mem_seen) begin
        if ($urandom_range(0, 7) != 0) mem_req = 1'b0;
      end else if (!mem_req && $urandom_range(0, 1) == 0) begin
        mem_req = 1'b1; mem_we = 1'($urandom_range(0, 1));
        mem_addr = $urandom; mem_wdata = $urandom;
      end
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b1;
        #1 chk("rnd_rst_en", 32'(bus_en), 32'd0);
        @(posedge clk); #2 rst = 1'b0;
      end
      @(negedge clk);
      if_seen = if_ack; mem_seen = mem_ack;
    end

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, fixed-latency unified memory between the pipeline's instruction fetch (IF) and the load/store access from the MEM stage. The arbiter sequences each access through a grant, wait-state and acknowledge state machine. It produces per-requester stall signals that the pipeline registers use to freeze. By default, data accesses have priority over fetch. An optional starvation guard forces a fetch grant after a bounded number of consecutive data wins.

## Interface

Parameters:
- LAT, default 2: memory access latency in cycles; legal range 1..15.
- STARVE_MAX, default 4: number of consecutive MEM grants with IF pending before IF is forced; legal range 1..15.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- if_req, input, 1: fetch request; held high until if_ack.
- if_addr, input, 32: fetch byte address.
- if_ack, output, 1: one-cycle completion pulse for a fetch.
- if_rdata, output, 32: fetched word; valid while if_ack=1.
- mem_req, input, 1: data request; held high until mem_ack.
- mem_we, input, 1: 1 = store, 0 = load.
- mem_addr, input, 32: data byte address.
- mem_wdata, input, 32: store data.
- mem_ack, output, 1: one-cycle completion pulse for a data access.
- mem_rdata, output, 32: load data; valid while mem_ack=1; 0 for stores.
- stall_if, output, 1: if_req & ~if_ack (combinational).
- stall_mem, output, 1: mem_req & ~mem_ack (combinational).
- bus_en, output, 1: memory access active.
- bus_we, output, 1: memory write enable; asserted only with bus_en.
- bus_addr, output, 32: latched address.
- bus_wdata, output, 32: latched store data.
- bus_rdata, input, 32: memory read data; valid in the last BUSY cycle.

## Operation

- States: IDLE, BUSY, DONE. Owner register: gnt_mem (1 = MEM, 0 = IF).
- IDLE:
  - If neither request is high, remain in IDLE.
  - If exactly one request is high, grant that requester.
  - If both are high, grant MEM unless the starvation counter equals STARVE_MAX, in which case grant IF.
  - On a grant: latch the address (and, for MEM, we and wdata), load the wait counter with LAT-1, and go to BUSY.
- BUSY:
  - bus_en=1; bus_we=gnt_mem & latched we; bus_addr and bus_wdata come from the latches.
  - Decrement the wait counter each cycle.
  - When the counter reaches 0: capture bus_rdata into the owner's rdata register (store: capture 0 instead) and go to DONE.
- DONE:
  - Assert the owner's ack for exactly one cycle; bus_en=0.
  - Requests are ignored in this state.
  - Next state is always IDLE.
- Starvation counter (4 bits):
  - Increments on each MEM grant made while if_req=1.
  - Clears on any IF grant.
  - Saturates at STARVE_MAX.
- Stores are rewritten on each BUSY cycle with identical address and data. The memory must tolerate repeated identical writes.
- Addresses are passed through unmodified. Word alignment is the memory's concern.
- A request that drops before its ack does not abort an access in progress; the ack is still issued.

## Timing

- Reset values: state=IDLE, if_ack=0, mem_ack=0, if_rdata=0, mem_rdata=0, bus_en=0, bus_we=0, bus_addr=0, bus_wdata=0, starvation counter=0.
- Reset is asynchronous, so outputs return to these values immediately. An access in progress is discarded and no ack is issued.
- Per-access timeline, with the request first seen in IDLE at cycle 0:
  - Cycles 1..LAT: BUSY, bus_en=1.
  - Cycle LAT+1: DONE, ack=1 and rdata valid.
  - Cycle LAT+2: IDLE; the next arbitration happens here.
- Minimum spacing between grants is LAT+2 cycles.
- The requester samples rdata at the edge that ends the ack cycle. It must drop req in cycle LAT+2 or it will be re-granted.
- stall_X is high from the first cycle of req through the cycle before ack.

## Configuration

- MEM_ARB_STARVE_GUARD_EN:
  - Defined: the starvation counter and forced IF grant are present, as described above.
  - Undefined: the counter is not built, and MEM always wins when both requests are high (strict priority). STARVE_MAX is then unused.

## Test plan

- Single IF read, LAT=2, if_addr=0x0000_0010, bus_rdata=0x0010_0093: bus_en high in cycles 1–2 with bus_addr=0x10; if_ack=1 in cycle 3 with if_rdata=0x0010_0093; stall_if high in cycles 0–2.
- MEM store, LAT=2, addr=0x4000, wdata=0xDEAD_BEEF: bus_we=1 in cycles 1–2 only; mem_ack in cycle 3; mem_rdata=0; if_ack never asserted.
- Both requests raised together in cycle 0: MEM granted (mem_ack in cycle 3); IF granted at cycle 4 (if_ack in cycle 7).
- Guard enabled, STARVE_MAX=4, if_req held high while mem_req is re-raised every time: 4 consecutive MEM grants, then the 5th grant goes to IF. With the guard disabled, IF is never granted while mem_req stays high.
- rst pulsed in cycle 2 of a BUSY load: bus_en drops immediately; no ack is issued afterwards; state returns to IDLE; a new request after reset completes normally.
